// File: rtl/pla_sweep_checker.sv
// Exhaustive input sweep for a reference/optimized PLA pair: compares the two outputs
// per vector, tracks mismatches and the first failing vector, and MISR-compresses y_dut.
module pla_sweep_checker #(
    parameter int unsigned      N_IN     = 12,
    parameter int unsigned      LAT      = 0,
    parameter int unsigned      SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_o,
    input  logic             y_ref,
    input  logic             y_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    mism_cnt,
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_vld,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

    localparam logic [N_IN-1:0] VecMax    = '1;
    localparam logic [N_IN:0]   CntMax    = {1'b1, {N_IN{1'b0}}};
    localparam logic [2:0]      DrainLast = 3'((LAT == 0) ? 0 : LAT - 1);

    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [2:0]       drain_q, drain_d;
    logic [N_IN:0]    mism_q, mism_d;
    logic [N_IN-1:0]  ff_q, ff_d;
    logic             ffv_q, ffv_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;
    logic             flush;
    logic             smp_vld;
    logic [N_IN-1:0]  smp_vec;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDrive;
                    vec_d   = '0;
                end
            end
            StDrive: begin
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                    flush   = 1'b1;
                end else if (vec_q == VecMax) begin
                    state_d = (LAT == 0) ? StDone : StDrain;
                    drain_d = '0;
                end else begin
                    vec_d = vec_q + N_IN'(1);
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                    flush   = 1'b1;
                end else if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                vec_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Delay {valid, vector} by LAT so each sample lines up with the netlist pipeline.
    if (LAT == 0) begin : g_no_pipe
        assign smp_vld = (state_q == StDrive);
        assign smp_vec = vec_q;
    end else begin : g_pipe
        logic [LAT-1:0]  pipe_vld_q;
        logic [N_IN-1:0] pipe_vec_q [LAT];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                pipe_vld_q <= '0;
            end else begin
                pipe_vld_q[0] <= (state_q == StDrive);
                for (int i = 1; i < int'(LAT); i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
            pipe_vec_q[0] <= vec_q;
            for (int i = 1; i < int'(LAT); i++) pipe_vec_q[i] <= pipe_vec_q[i-1];
        end

        assign smp_vld = pipe_vld_q[LAT-1];
        assign smp_vec = pipe_vec_q[LAT-1];
    end

    always_comb begin
        mism_d = mism_q;
        ff_d   = ff_q;
        ffv_d  = ffv_q;
        sig_d  = sig_q;
        pass_d = pass_q;
        if (state_q == StIdle && start) begin
            mism_d = '0;
            ff_d   = '0;
            ffv_d  = 1'b0;
            sig_d  = SIG_SEED;
            pass_d = 1'b0;
        end else if (smp_vld && !flush) begin
            if (y_ref != y_dut) begin
                if (mism_q != CntMax) mism_d = mism_q + (N_IN+1)'(1);
                if (!ffv_q) begin
                    ff_d  = smp_vec;
                    ffv_d = 1'b1;
                end
            end
            sig_d = {sig_q[SIG_W-2:0], y_dut} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0);
        end
        if (flush) pass_d = 1'b0;
        // The final sample lands on the same edge that enters StDone, so use mism_d.
        if (state_d == StDone && state_q != StDone) pass_d = (mism_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            drain_q <= '0;
            mism_q  <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            sig_q   <= SIG_SEED;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            drain_q <= drain_d;
            mism_q  <= mism_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_o          = vec_q;
    assign busy           = (state_q == StDrive) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign mism_cnt       = mism_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;
    assign signature      = sig_q;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Bench for pla_sweep_checker: three instances (LAT 0, 1, 3) share control inputs and
// see truth-table netlists whose outputs are delayed by each instance's LAT.
module tb_pla_sweep_checker;

    logic clk = 1'b0;
    logic rst, start, abort;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bit tt_ref [4096];
    bit tt_dut [4096];

    wire [11:0] vec  [3];
    wire [12:0] mism [3];
    wire [11:0] ff   [3];
    wire [15:0] sig  [3];
    wire [2:0]  busy, done, pass, ffv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [11:0] hist [8];
        logic [11:0] dv;
        logic        yr, yd;

        always @(posedge clk) begin
            hist[0] <= vec[g];
            for (int j = 1; j < 8; j++) hist[j] <= hist[j-1];
        end
        assign dv = (L == 0) ? vec[g] : hist[(L == 0) ? 0 : L - 1];
        always_comb begin
            yr = tt_ref[dv];
            yd = tt_dut[dv];
        end

        pla_sweep_checker #(
            .N_IN(12), .LAT(L), .SIG_W(16), .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_o(vec[g]),
            .y_ref(yr), .y_dut(yd), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .mism_cnt(mism[g]), .first_fail(ff[g]), .first_fail_vld(ffv[g]),
            .signature(sig[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void fill(input int mode);
        for (int v = 0; v < 4096; v++) begin
            case (mode)
                0: begin tt_ref[v] = 1'(v % 2); tt_dut[v] = 1'(v % 2); end
                1: begin tt_ref[v] = 1'(v % 2); tt_dut[v] = 1'(v % 2) ^ (v == 'h0A5); end
                2: begin tt_ref[v] = 1'(v % 2); tt_dut[v] = ~1'(v % 2); end
                default: begin
                    tt_ref[v] = 1'($urandom_range(0, 1));
                    tt_dut[v] = tt_ref[v] ^ ($urandom_range(0, 1023) == 0);
                end
            endcase
        end
    endfunction

    // Reference: walk the first n vectors in order, as sampled by a completed sweep.
    function automatic void model(input int n, output int m, output int f, output int fv,
                                  output int s);
        m = 0; f = 0; fv = 0; s = 'hFFFF;
        for (int v = 0; v < n; v++) begin
            if (tt_ref[v] != tt_dut[v]) begin
                if (fv == 0) begin f = v; fv = 1; end
                m++;
            end
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 'h1021 : 0) ^ int'(tt_dut[v]);
        end
    endfunction

    task automatic check_reset(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s lat%0d vec", tag, lat_of(g)), vec[g], 0);
            check($sformatf("%s lat%0d busy", tag, lat_of(g)), busy[g], 0);
            check($sformatf("%s lat%0d done", tag, lat_of(g)), done[g], 0);
            check($sformatf("%s lat%0d pass", tag, lat_of(g)), pass[g], 0);
            check($sformatf("%s lat%0d mism", tag, lat_of(g)), mism[g], 0);
            check($sformatf("%s lat%0d ff", tag, lat_of(g)), ff[g], 0);
            check($sformatf("%s lat%0d ffv", tag, lat_of(g)), ffv[g], 0);
            check($sformatf("%s lat%0d sig", tag, lat_of(g)), sig[g], 'hFFFF);
        end
    endtask

    task automatic do_sweep(input string tag, input int e_mism, input int e_ff, input int e_ffv,
                            input int e_pass, input int e_sig, input bit poke);
        int s;
        int npulse [3];
        int dcyc [3];
        logic [12:0] s_mism [3];
        logic [11:0] s_ff [3];
        logic [15:0] s_sig [3];
        logic s_ffv [3], s_pass [3], s_busy [3];
        for (int g = 0; g < 3; g++) begin
            npulse[g] = 0; dcyc[g] = -1;
            s_mism[g] = '0; s_ff[g] = '0; s_sig[g] = '0;
            s_ffv[g] = 1'b0; s_pass[g] = 1'b0; s_busy[g] = 1'b1;
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        s = cyc;
        for (int t = 1; t <= 4120; t++) begin
            if (poke && t == 50) start = 1'b1;
            if (poke && t == 51) start = 1'b0;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (done[g]) begin
                    npulse[g]++;
                    if (npulse[g] == 1) begin
                        dcyc[g] = cyc - s;
                        s_mism[g] = mism[g]; s_ff[g] = ff[g]; s_ffv[g] = ffv[g];
                        s_pass[g] = pass[g]; s_sig[g] = sig[g]; s_busy[g] = busy[g];
                    end
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s lat%0d done_pulses", tag, lat_of(g)), npulse[g], 1);
            check($sformatf("%s lat%0d done_cycle", tag, lat_of(g)), dcyc[g], 4096 + lat_of(g));
            check($sformatf("%s lat%0d busy_at_done", tag, lat_of(g)), s_busy[g], 0);
            check($sformatf("%s lat%0d mism", tag, lat_of(g)), s_mism[g], e_mism);
            check($sformatf("%s lat%0d ff", tag, lat_of(g)), s_ff[g], e_ff);
            check($sformatf("%s lat%0d ffv", tag, lat_of(g)), s_ffv[g], e_ffv);
            check($sformatf("%s lat%0d pass", tag, lat_of(g)), s_pass[g], e_pass);
            check($sformatf("%s lat%0d sig", tag, lat_of(g)), s_sig[g], e_sig);
            check($sformatf("%s lat%0d pass_hold", tag, lat_of(g)), pass[g], e_pass);
        end
    endtask

    typedef struct {
        int mode;
        int mism;
        int ff;
        int ffv;
        int pass;
    } rec_t;

    initial begin
        rec_t tab [3];
        int m, f, fv, sg, t, nd;

        tab[0] = '{mode: 0, mism: 0,    ff: 0,     ffv: 0, pass: 1};
        tab[1] = '{mode: 1, mism: 1,    ff: 'h0A5, ffv: 1, pass: 0};
        tab[2] = '{mode: 2, mism: 4096, ff: 0,     ffv: 1, pass: 0};

        start = 1'b0; abort = 1'b0; rst = 1'b1;
        fill(0);
        repeat (3) @(negedge clk);
        check_reset("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");

        for (int i = 0; i < 3; i++) begin
            fill(tab[i].mode);
            model(4096, m, f, fv, sg);
            do_sweep($sformatf("tab%0d", i), tab[i].mism, tab[i].ff, tab[i].ffv, tab[i].pass,
                     sg, 1'b0);
        end

        for (int i = 0; i < 2; i++) begin
            fill(3);
            model(4096, m, f, fv, sg);
            do_sweep($sformatf("rand%0d", i), m, f, fv, (m == 0) ? 1 : 0, sg, 1'b0);
        end

        fill(1);
        model(4096, m, f, fv, sg);
        do_sweep("start_poke", tab[1].mism, tab[1].ff, tab[1].ffv, tab[1].pass, sg, 1'b1);

        // Abort while vector 100 is driven.
        fill(1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t = 0;
        while (vec[0] != 12'd100 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("abort reached vec100", (vec[0] == 12'd100), 1);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        for (int g = 0; g < 3; g++) begin
            model(100 - lat_of(g), m, f, fv, sg);
            check($sformatf("abort lat%0d busy", lat_of(g)), busy[g], 0);
            check($sformatf("abort lat%0d vec", lat_of(g)), vec[g], 0);
            check($sformatf("abort lat%0d pass", lat_of(g)), pass[g], 0);
            check($sformatf("abort lat%0d mism", lat_of(g)), mism[g], m);
            check($sformatf("abort lat%0d ffv", lat_of(g)), ffv[g], fv);
            check($sformatf("abort lat%0d sig", lat_of(g)), sig[g], sg);
        end
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            nd += int'(done[0]) + int'(done[1]) + int'(done[2]);
        end
        check("abort no_done", nd, 0);
        check("abort pass_hold", pass, 0);

        // Reset while vector 2000 is driven, then a clean sweep.
        fill(1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t = 0;
        while (vec[0] != 12'd2000 && t < 2200) begin
            @(negedge clk);
            t++;
        end
        check("rst reached vec2000", (vec[0] == 12'd2000), 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_reset("mid_rst");
        fill(0);
        model(4096, m, f, fv, sg);
        do_sweep("after_rst", tab[0].mism, tab[0].ff, tab[0].ffv, tab[0].pass, sg, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
